// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem read per cycle
// and buffers returned {PC+1, insn} pairs in a DEPTH-entry circular queue for decode.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INSN_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_WIDTH-1:0]        address_imem,
  output logic                         imem_req,
  input  logic [INSN_WIDTH-1:0]        q_imem,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSN_WIDTH-1:0]        out_insn,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_valid_q, inflight_valid_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [INSN_WIDTH-1:0] insn_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];

  logic [CW:0] credit;
  logic        issue;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Decode handshake: an entry transfers on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and redirect cancels any transfer.
  assign out_valid    = (count_q != '0);
  assign out_insn     = insn_mem_q[rd_ptr_q];
  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign occupancy    = count_q;
  assign address_imem = fetch_pc_q;
  assign imem_req     = issue;

  // The in-flight read always holds a reserved slot, so a push can never overflow.
  assign credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_valid_q};
  assign issue  = ~redirect & (credit < DEPTH_C);
  assign push   = ~redirect & inflight_valid_q;
  assign pop    = ~redirect & out_valid & out_ready;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    if (redirect) begin
      fetch_pc_d       = redirect_pc;
      inflight_valid_d = 1'b0;
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      count_d          = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      inflight_valid_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage is cleared on reset so the head outputs are never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      insn_mem_q[wr_ptr_q] <= q_imem;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table on a DEPTH=4 instance plus a
// PC/pointer wrap sequence on an ADDR_WIDTH=4, DEPTH=3, RESET_PC=14 instance.
module tb_fetch_queue;

  logic clock;

  // ---------------- instance A: defaults ----------------
  logic        rst_a;
  logic [31:0] address_a;
  logic        req_a;
  logic [31:0] q_a;
  logic        redirect_a;
  logic [31:0] redirect_pc_a;
  logic        valid_a;
  logic        ready_a;
  logic [31:0] insn_a;
  logic [31:0] pc_a;
  logic [2:0]  occ_a;

  fetch_queue dut_a (
    .clock        (clock),
    .reset        (rst_a),
    .address_imem (address_a),
    .imem_req     (req_a),
    .q_imem       (q_a),
    .redirect     (redirect_a),
    .redirect_pc  (redirect_pc_a),
    .out_valid    (valid_a),
    .out_ready    (ready_a),
    .out_insn     (insn_a),
    .out_pc       (pc_a),
    .occupancy    (occ_a)
  );

  // ---------------- instance B: narrow PC, odd depth ----------------
  logic        rst_b;
  logic [3:0]  address_b;
  logic        req_b;
  logic [31:0] q_b;
  logic        redirect_b;
  logic [3:0]  redirect_pc_b;
  logic        valid_b;
  logic        ready_b;
  logic [31:0] insn_b;
  logic [3:0]  pc_b;
  logic [1:0]  occ_b;

  fetch_queue #(
    .ADDR_WIDTH (4),
    .INSN_WIDTH (32),
    .DEPTH      (3),
    .RESET_PC   (4'd14)
  ) dut_b (
    .clock        (clock),
    .reset        (rst_b),
    .address_imem (address_b),
    .imem_req     (req_b),
    .q_imem       (q_b),
    .redirect     (redirect_b),
    .redirect_pc  (redirect_pc_b),
    .out_valid    (valid_b),
    .out_ready    (ready_b),
    .out_insn     (insn_b),
    .out_pc       (pc_b),
    .occupancy    (occ_b)
  );

  // ---------------- clock / imem responders ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One-cycle-latency imem returning 0x100 + address.
  always @(posedge clock) begin
    q_a <= 32'h100 + address_a;
    q_b <= 32'h100 + {28'd0, address_b};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic redir, input logic [31:0] rpc,
                     input logic rdy, input logic chk, input logic req,
                     input logic [31:0] addr, input logic valid,
                     input logic [31:0] insn, input logic [31:0] pc,
                     input logic [2:0] occ);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.chk = chk;
    v.req = req; v.addr = addr; v.valid = valid; v.insn = insn; v.pc = pc; v.occ = occ;
    vecs.push_back(v);
  endtask

  // Wrap-test scoreboard: {out_pc, out_insn} and the expected request addresses.
  logic [35:0] exp_q[$];
  logic [3:0]  addr_q[$];

  initial begin
    rst_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = '0; ready_a = 1'b0;
    rst_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; ready_b = 1'b0;

    //   rst redir rpc    rdy chk req addr   valid insn    pc     occ
    // Stream from reset, then redirect together with a pop.
    add(1, 0, 0,      1,  0,  0,  0,     0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  0,     0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  1,     0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  2,     1,    'h100,  1,     1);
    add(0, 0, 0,      1,  1,  1,  3,     1,    'h101,  2,     1);
    add(0, 1, 'h20,   1,  1,  0,  4,     1,    'h102,  3,     1);
    add(0, 0, 0,      1,  1,  1,  'h20,  0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  'h21,  0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  'h22,  1,    'h120,  'h21,  1);
    add(0, 0, 0,      1,  1,  1,  'h23,  1,    'h121,  'h22,  1);
    // Backpressure: fill to DEPTH, one-cycle ready pulse, then reset mid-flight.
    add(1, 0, 0,      0,  0,  0,  0,     0,    0,      0,     0);
    add(0, 0, 0,      0,  1,  1,  0,     0,    0,      0,     0);
    add(0, 0, 0,      0,  1,  1,  1,     0,    0,      0,     0);
    add(0, 0, 0,      0,  1,  1,  2,     1,    'h100,  1,     1);
    add(0, 0, 0,      0,  1,  1,  3,     1,    'h100,  1,     2);
    add(0, 0, 0,      0,  1,  0,  4,     1,    'h100,  1,     3);
    add(0, 0, 0,      0,  1,  0,  4,     1,    'h100,  1,     4);
    add(0, 0, 0,      0,  1,  0,  4,     1,    'h100,  1,     4);
    add(0, 0, 0,      1,  1,  0,  4,     1,    'h100,  1,     4);
    add(0, 0, 0,      0,  1,  1,  4,     1,    'h101,  2,     3);
    add(1, 0, 0,      0,  1,  0,  5,     1,    'h101,  2,     3);
    // After reset: redirect while a response is in flight.
    add(0, 0, 0,      0,  1,  1,  0,     0,    0,      0,     0);
    add(0, 0, 0,      0,  1,  1,  1,     0,    0,      0,     0);
    add(0, 0, 0,      0,  1,  1,  2,     1,    'h100,  1,     1);
    add(0, 1, 'h40,   0,  1,  0,  3,     1,    'h100,  1,     2);
    add(0, 0, 0,      1,  1,  1,  'h40,  0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  'h41,  0,    0,      0,     0);
    add(0, 0, 0,      1,  1,  1,  'h42,  1,    'h140,  'h41,  1);
    add(0, 0, 0,      1,  1,  1,  'h43,  1,    'h141,  'h42,  1);
    add(0, 0, 0,      1,  1,  1,  'h44,  1,    'h142,  'h43,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      rst_a         = vecs[i].rst;
      redirect_a    = vecs[i].redir;
      redirect_pc_a = vecs[i].rpc;
      ready_a       = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        check("imem_req", i, {31'd0, req_a}, {31'd0, vecs[i].req});
        check("address_imem", i, address_a, vecs[i].addr);
        check("out_valid", i, {31'd0, valid_a}, {31'd0, vecs[i].valid});
        check("occupancy", i, {29'd0, occ_a}, {29'd0, vecs[i].occ});
        if (vecs[i].valid) begin
          check("out_insn", i, insn_a, vecs[i].insn);
          check("out_pc", i, pc_a, vecs[i].pc);
        end
      end
    end
    @(negedge clock);
    rst_a = 1'b1; redirect_a = 1'b0; ready_a = 1'b0;

    // ---------------- wrap sequence on instance B ----------------
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = 4'(14 + i);
      addr_q.push_back(a);
      exp_q.push_back({a + 4'd1, 32'h100 + {28'd0, a}});
    end
    @(negedge clock);
    rst_b = 1'b1;
    @(negedge clock);
    rst_b = 1'b0;
    begin
      int delivered;
      int req_seen;
      logic [35:0] e;
      delivered = 0;
      req_seen  = 0;
      for (int c = 0; c < 300 && delivered < 20; c++) begin
        if (c != 0) @(negedge clock);
        ready_b = (c % 2 == 0);
        #1;
        if (req_b && req_seen < 20) begin
          check("wrap_fetch_addr", req_seen, {28'd0, address_b}, {28'd0, addr_q.pop_front()});
          req_seen++;
        end
        if (valid_b && ready_b) begin
          if (exp_q.size() == 0) begin
            check("wrap_extra_output", delivered, {28'd0, pc_b}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wrap_out_pc", delivered, {28'd0, pc_b}, {28'd0, e[35:32]});
            check("wrap_out_insn", delivered, insn_b, e[31:0]);
          end
          delivered++;
        end
      end
      check("wrap_delivered", 0, delivered, 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
